alu_mul_ctrl: RTL

ALU_MUL_CTRL -- requirements
Module: alu_mul_ctrl

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_ctrl_if.sv | 33 +++
 rtl/alu_mul_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shift-add multiplier controller and the 8-bit ALU.
// Holds the ALU operation codes, the controller FSM state encoding and the
// datapath widths. Import with: import alu_pkg::*;
package alu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MUL_BITS = 8;

  // Operation codes understood by the shared ALU
  typedef enum logic [OP_W-1:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_ORR = 3'd4,
    ALU_LSL = 3'd5,
    ALU_LSR = 3'd6
  } alu_op_e;

  // Multiplier controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } mul_state_e;

endpackage

// File: rtl/alu_mul_ctrl_if.sv
// Bundle between a multiply requester, the multiplier controller and the
// shared ALU.
//   start/a/b             : request side, sampled by the controller in IDLE
//   busy/done/product     : controller status and result
//   alu_op1/alu_op2/alu_operation/alu_is_signed : controller -> ALU operands
//   alu_result            : ALU -> controller combinational result
// Modports: slave = controller view, master = environment (requester + ALU).
interface alu_mul_ctrl_if;
  import alu_pkg::*;

  logic                  start;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     product;
  logic [DATA_W-1:0]     alu_op1;
  logic [DATA_W-1:0]     alu_op2;
  logic [OP_W-1:0]       alu_operation;
  logic                  alu_is_signed;
  logic [DATA_W-1:0]     alu_result;

  modport slave (
    input  start, a, b, alu_result,
    output busy, done, product, alu_op1, alu_op2, alu_operation, alu_is_signed
  );

  modport master (
    output start, a, b, alu_result,
    input  busy, done, product, alu_op1, alu_op2, alu_operation, alu_is_signed
  );

endinterface

// File: rtl/alu_mul_ctrl.sv
// Shift-and-add 8x8 unsigned multiplier controller that borrows a shared
// 8-bit ALU (instantiated by the parent) for its add and shift steps.
// Result is a*b mod 256, reported on product with a one-cycle done pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_mul_ctrl_if.slave (start/a/b in, busy/done/product out,
//           ALU operand/opcode out, alu_result in)
// Build option: define ALU_MUL_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero (b==0 completes straight from IDLE).
module alu_mul_ctrl
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_mul_ctrl_if.slave  bus
);

  mul_state_e         state_q, state_n;
  logic [DATA_W-1:0]  acc_q, acc_n;
  logic [DATA_W-1:0]  mcand_q, mcand_n;
  logic [DATA_W-1:0]  mplier_q, mplier_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [DATA_W-1:0]  product_q, product_n;
  logic [DATA_W-1:0]  op1_q, op1_n;
  logic [DATA_W-1:0]  op2_q, op2_n;
  alu_op_e            oper_q, oper_n;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      oper_q    <= ALU_NOP;
    end else begin
      state_q   <= state_n;
      acc_q     <= acc_n;
      mcand_q   <= mcand_n;
      mplier_q  <= mplier_n;
      cnt_q     <= cnt_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      product_q <= product_n;
      op1_q     <= op1_n;
      op2_q     <= op2_n;
      oper_q    <= oper_n;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_n   = state_q;
    acc_n     = acc_q;
    mcand_n   = mcand_q;
    mplier_n  = mplier_q;
    cnt_n     = cnt_q;
    product_n = product_q;
    oper_n    = ALU_NOP;
    op1_n     = '0;
    op2_n     = '0;

    // Status flags trail the state by one cycle, which places done in the
    // cycle after the DONE state and gives busy its 16-cycle window.
    busy_n = (state_q == S_ADD) || (state_q == S_SHIFT);
    done_n = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_n  = bus.a;
          mplier_n = bus.b;
          acc_n    = '0;
          cnt_n    = '0;
`ifdef ALU_MUL_EARLY_EXIT_EN
          state_n  = (bus.b == '0) ? S_DONE : S_ADD;
`else
          state_n  = S_ADD;
`endif
        end
      end
      S_ADD: begin
        if (mplier_q[0]) acc_n = bus.alu_result;
        state_n = S_SHIFT;
      end
      S_SHIFT: begin
        mcand_n  = bus.alu_result;
        mplier_n = mplier_q >> 1;
        cnt_n    = cnt_q + CNT_W'(1);
`ifdef ALU_MUL_EARLY_EXIT_EN
        state_n  = ((cnt_n == CNT_W'(MUL_BITS)) || (mplier_n == '0)) ? S_DONE : S_ADD;
`else
        state_n  = (cnt_n == CNT_W'(MUL_BITS)) ? S_DONE : S_ADD;
`endif
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Capture the accumulator on entry to DONE so product is stable before done rises
    if (state_n == S_DONE) product_n = acc_n;

    // ALU request registered against the state it will be consumed in
    unique case (state_n)
      S_ADD: begin
        oper_n = ALU_ADD;
        op1_n  = acc_n;
        op2_n  = mcand_n;
      end
      S_SHIFT: begin
        oper_n = ALU_LSL;
        op1_n  = mcand_n;
        op2_n  = DATA_W'(1);
      end
      default: begin
        oper_n = ALU_NOP;
        op1_n  = '0;
        op2_n  = '0;
      end
    endcase
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.product       = product_q;
  assign bus.alu_op1       = op1_q;
  assign bus.alu_op2       = op2_q;
  assign bus.alu_operation = oper_q;
  assign bus.alu_is_signed = 1'b0;

endmodule
